// File: rtl/mux4x1_serializer_pkg.sv
// Shared state encoding, word type and constants for the 4x1 mux serializer.
package mux4x1_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [0:3] word_t;

    localparam logic [1:0] SEL_LAST           = 2'b11;
    localparam int         DEFAULT_BIT_CYCLES = 1;

endpackage

// File: rtl/mux4x1_serializer_if.sv
// Upstream word handshake into the serializer.
interface mux4x1_serializer_if;
    import mux4x1_serializer_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mux4x1_serializer_bit_period_timer.sv
// Bit-period counter: runs 0..BIT_CYCLES-1 while enabled and flags the last cycle.
module mux4x1_serializer_bit_period_timer #(
    parameter int BIT_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/mux4x1_serializer.sv
// Loads a 4-bit word onto the gate mux, steps its select 00..11 and serializes the
// returned mux output, flagging any bit that disagrees with the loaded word.
module mux4x1_serializer
    import mux4x1_serializer_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux4x1_serializer_if.slave in_bus,
    output word_t              mux_a,
    output logic [0:1]         mux_sel,
    input  logic               mux_f,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               done,
    output logic               err,
    input  logic               clr_err
);

    state_t     state;
    state_t     next_state;
    logic [1:0] sel_idx;
    logic       accept;
    logic       tc;
    logic       sample_bit;
    logic       mismatch;
    logic       timer_clr;
    logic       timer_en;

    assign in_bus.in_ready = (state == IDLE);
    assign accept          = in_bus.in_valid && (state == IDLE);
    assign mux_sel         = {sel_idx[1], sel_idx[0]};
    assign done            = (state == DONE);
    assign sample_bit      = (state == SHIFT) && tc;
    assign mismatch        = sample_bit && (mux_f != mux_a[sel_idx]);

    mux4x1_serializer_bit_period_timer #(
        .BIT_CYCLES(BIT_CYCLES),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (timer_en),
        .tc (tc)
    );

    always_comb begin
        next_state = state;
        timer_clr  = 1'b1;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (tc && (sel_idx == SEL_LAST)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A mismatch in the same cycle as clr_err must still leave err set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mux_a     <= '0;
            sel_idx   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            ser_valid <= sample_bit;
            if (accept) begin
                mux_a   <= in_bus.in_data;
                sel_idx <= '0;
            end
            if (sample_bit) begin
                ser_out <= mux_f;
                if (sel_idx != SEL_LAST) begin
                    sel_idx <= sel_idx + 2'd1;
                end
            end
            if (state == DONE) begin
                sel_idx <= '0;
            end
            if (mismatch) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux4x1_serializer.sv
// Bench for mux4x1_serializer: two instances (BIT_CYCLES 1 and 3) each feeding a
// behavioural 4x1 gate mux, with a queue of expected serial bits per frame.
module tb_mux4x1_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit exp_q[$];

    logic       rst_a = 1'b1;
    logic       clr_err_a = 1'b0;
    logic       fault_a = 1'b0;
    logic [0:3] mux_a_a;
    logic [0:1] mux_sel_a;
    logic       mux_f_a;
    logic       ser_out_a, ser_valid_a, done_a, err_a;

    logic       rst_b = 1'b1;
    logic       clr_err_b = 1'b0;
    logic [0:3] mux_a_b;
    logic [0:1] mux_sel_b;
    logic       mux_f_b;
    logic       ser_out_b, ser_valid_b, done_b, err_b;

    mux4x1_serializer_if bus_a();
    mux4x1_serializer_if bus_b();

    // Gate mux models; fault_a pins the A-side mux output low.
    assign mux_f_a = fault_a ? 1'b0 : mux_a_a[{mux_sel_a[0], mux_sel_a[1]}];
    assign mux_f_b = mux_a_b[{mux_sel_b[0], mux_sel_b[1]}];

    mux4x1_serializer #(.BIT_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .in_bus(bus_a.slave),
        .mux_a(mux_a_a), .mux_sel(mux_sel_a), .mux_f(mux_f_a),
        .ser_out(ser_out_a), .ser_valid(ser_valid_a), .done(done_a),
        .err(err_a), .clr_err(clr_err_a)
    );

    mux4x1_serializer #(.BIT_CYCLES(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .in_bus(bus_b.slave),
        .mux_a(mux_a_b), .mux_sel(mux_sel_b), .mux_f(mux_f_b),
        .ser_out(ser_out_b), .ser_valid(ser_valid_b), .done(done_b),
        .err(err_b), .clr_err(clr_err_b)
    );

    task automatic test_reset();
        logic [0:10] obs_a, obs_b, exp_v;
        exp_v = 11'b0000_00_0000_1;
        bus_a.in_valid = 1'b0; bus_a.in_data = 4'b0000;
        bus_b.in_valid = 1'b0; bus_b.in_data = 4'b0000;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs_a = {mux_a_a, mux_sel_a, ser_out_a, ser_valid_a, done_a, err_a, bus_a.in_ready};
        obs_b = {mux_a_b, mux_sel_b, ser_out_b, ser_valid_b, done_b, err_b, bus_b.in_ready};
        tests_run++;
        if (obs_a !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL reset_a: got %b want %b", obs_a, exp_v);
        end
        tests_run++;
        if (obs_b !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL reset_b: got %b want %b", obs_b, exp_v);
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_basic();
        logic [0:3] w;
        logic [0:5] sv_h, done_h, rdy_h, sv_e, done_e, rdy_e;
        logic       b;
        w = 4'b0101; sv_e = 6'b011110; done_e = 6'b000010; rdy_e = 6'b000001;
        exp_q.delete();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            sv_h[c] = ser_valid_a; done_h[c] = done_a; rdy_h[c] = bus_a.in_ready;
            if (ser_valid_a) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL basic_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        tests_run++;
        if (sv_h !== sv_e) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid_timing: got %b want %b", sv_h, sv_e);
        end
        tests_run++;
        if (done_h !== done_e) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_timing: got %b want %b", done_h, done_e);
        end
        tests_run++;
        if (rdy_h !== rdy_e) begin
            tests_failed++;
            $display("[TB] FAIL basic_ready_timing: got %b want %b", rdy_h, rdy_e);
        end
        tests_run++;
        if (err_a !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_err_drain: err %b left %0d want err 0 left 0", err_a, exp_q.size());
        end
    endtask

    task automatic test_slow();
        logic [0:3]  w;
        logic [0:13] sv_h, done_h, rdy_h, sv_e, done_e, rdy_e;
        logic        b;
        w = 4'b1110;
        for (int c = 0; c < 14; c++) begin
            sv_e[c]   = (c > 0) && (c % 3 == 0);
            done_e[c] = (c == 12);
            rdy_e[c]  = (c == 13);
        end
        exp_q.delete();
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b0;
            sv_h[c] = ser_valid_b; done_h[c] = done_b; rdy_h[c] = bus_b.in_ready;
            if (ser_valid_b) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_b !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL slow_bit c%0d: got %b want %b", c, ser_out_b, b);
                end
            end
        end
        tests_run++;
        if (sv_h !== sv_e) begin
            tests_failed++;
            $display("[TB] FAIL slow_valid_timing: got %b want %b", sv_h, sv_e);
        end
        tests_run++;
        if ({done_h, rdy_h} !== {done_e, rdy_e}) begin
            tests_failed++;
            $display("[TB] FAIL slow_done_ready: got %b want %b", {done_h, rdy_h}, {done_e, rdy_e});
        end
    endtask

    task automatic test_back_to_back();
        logic [0:3]  w1, w2;
        logic [0:11] sv_h, done_h, rdy_h, sv_e, done_e, rdy_e;
        logic        b;
        w1 = 4'b1001; w2 = 4'b0110;
        for (int c = 0; c < 12; c++) begin
            sv_e[c]   = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            done_e[c] = (c == 4) || (c == 10);
            rdy_e[c]  = (c == 5) || (c == 11);
        end
        exp_q.delete();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w1;
        for (int k = 0; k < 4; k++) exp_q.push_back(w1[k]);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            // The second word sits on the bus while busy and must wait for in_ready.
            if (c == 0) begin
                bus_a.in_data = w2;
                for (int k = 0; k < 4; k++) exp_q.push_back(w2[k]);
            end
            if (c == 6) bus_a.in_valid = 1'b0;
            sv_h[c] = ser_valid_a; done_h[c] = done_a; rdy_h[c] = bus_a.in_ready;
            if (ser_valid_a) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        bus_a.in_valid = 1'b0;
        tests_run++;
        if (sv_h !== sv_e) begin
            tests_failed++;
            $display("[TB] FAIL b2b_valid_timing: got %b want %b", sv_h, sv_e);
        end
        tests_run++;
        if ({done_h, rdy_h} !== {done_e, rdy_e}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_done_ready: got %b want %b", {done_h, rdy_h}, {done_e, rdy_e});
        end
    endtask

    task automatic test_mid_reset();
        logic [0:3]  w;
        logic [0:10] obs, exp_v;
        logic [0:5]  sv_h, done_h;
        logic        b;
        int          npulse, quiet;
        w = 4'b0011; exp_v = 11'b0000_00_0000_1; npulse = 0; quiet = 0;
        exp_q.delete();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            if (ser_valid_a) begin
                npulse++;
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        exp_q.delete();
        obs = {mux_a_a, mux_sel_a, ser_out_a, ser_valid_a, done_a, err_a, bus_a.in_ready};
        tests_run++;
        if (obs !== exp_v || npulse != 2) begin
            tests_failed++;
            $display("[TB] FAIL midrst_state: got %b pulses %0d want %b pulses 2", obs, npulse, exp_v);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ser_valid_a || done_a) quiet++;
        end
        tests_run++;
        if (quiet != 0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_quiet: got %0d stray cycles want 0", quiet);
        end
        w = 4'b1000;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            sv_h[c] = ser_valid_a; done_h[c] = done_a;
            if (ser_valid_a) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_new_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        tests_run++;
        if ({sv_h, done_h} !== {6'b011110, 6'b000010}) begin
            tests_failed++;
            $display("[TB] FAIL midrst_new_timing: got %b want %b", {sv_h, done_h}, {6'b011110, 6'b000010});
        end
    endtask

    task automatic test_fault();
        logic [0:5] err_h, err_e;
        logic       b;
        err_e = 6'b001111;
        // Frame 1: stuck-low mux, so every returned bit is 0.
        exp_q.delete();
        fault_a = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'b0101;
        for (int k = 0; k < 4; k++) exp_q.push_back(1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            err_h[c] = err_a;
            if (ser_valid_a) begin
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL fault_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        tests_run++;
        if (err_h !== err_e) begin
            tests_failed++;
            $display("[TB] FAIL fault_err_history: got %b want %b", err_h, err_e);
        end
        // Frame 2: healthy mux; a new frame must not clear the sticky flag.
        fault_a = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
        end
        tests_run++;
        if (err_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL fault_err_sticky: got %b want 1", err_a);
        end
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
        tests_run++;
        if (err_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fault_clr_idle: got %b want 0", err_a);
        end
        // Frame 3: clr_err lands on the same edge as the sel=01 mismatch.
        fault_a = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            err_h[c] = err_a;
            clr_err_a = (c == 1);
        end
        tests_run++;
        if (err_h !== err_e) begin
            tests_failed++;
            $display("[TB] FAIL fault_clr_vs_mismatch: got %b want %b", err_h, err_e);
        end
        fault_a = 1'b0;
        clr_err_a = 1'b1;
        @(negedge clk);
        clr_err_a = 1'b0;
    endtask

    task automatic test_done_reset();
        logic [0:3]  w;
        logic [0:10] obs, exp_v;
        logic        b;
        int          npulse, quiet;
        w = 4'b1101; exp_v = 11'b0000_00_0000_1; npulse = 0; quiet = 0;
        exp_q.delete();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b0;
            if (ser_valid_a) begin
                npulse++;
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                tests_run++;
                if (ser_out_a !== b) begin
                    tests_failed++;
                    $display("[TB] FAIL donerst_bit c%0d: got %b want %b", c, ser_out_a, b);
                end
            end
        end
        // Reset on the edge that would otherwise enter DONE.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        obs = {mux_a_a, mux_sel_a, ser_out_a, ser_valid_a, done_a, err_a, bus_a.in_ready};
        tests_run++;
        if (obs !== exp_v || npulse != 3) begin
            tests_failed++;
            $display("[TB] FAIL donerst_state: got %b pulses %0d want %b pulses 3", obs, npulse, exp_v);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ser_valid_a || done_a) quiet++;
        end
        tests_run++;
        if (quiet != 0) begin
            tests_failed++;
            $display("[TB] FAIL donerst_quiet: got %0d stray cycles want 0", quiet);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_back_to_back();
        test_mid_reset();
        test_fault();
        test_done_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
